sd_resp_rx: RTL and testbench
=============================

SD_RESP_RX -- requirements
Module: sd_resp_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum sample strobes waited for a start bit (NCR).
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: single-cycle pulse to arm the receiver for one response.
REQ-005 SHALL have port resp_type, input, 3: response kind, captured on start. Encodings: 1=R1, 2=R2-CID, 3=R2-CSD, 4=R3, 6=R6, 7=R7; others = no response.
REQ-006 SHALL have port bit_en, input, 1: CMD-line sample strobe, one per SD clock.
REQ-007 SHALL have port cmd_in, input, 1: serial CMD line, sampled only when bit_en=1.
REQ-008 SHALL have port busy, output, 1: receiver armed or receiving.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at end of every armed transaction.
REQ-010 SHALL have ports crc_err, end_err and timeout_err, outputs, 1 each: status flags, valid with done.
REQ-011 SHALL have port index, output, 6: received command index.
REQ-012 SHALL have port arg, output, 32: 48-bit response payload.
REQ-013 SHALL have port long_data, output, 128: R2 payload bits [127:1], with bit 0 forced to 1.
REQ-014 SHALL have ports stat_en, rca_en, ocr_en, cid_en and csd_en, outputs, 1 each: register-file load strobes.

Function
REQ-015 SHALL implement states IDLE, WAIT_START, RECV and FINISH.
REQ-016 In IDLE, start with a valid resp_type SHALL go to WAIT_START. start with no-response type SHALL pulse done the next cycle with all errors 0.
REQ-017 In WAIT_START, on each bit_en: cmd_in=0 SHALL go to RECV (start bit consumed); cmd_in=1 SHALL increment the timeout counter.
REQ-018 When the timeout counter reaches TIMEOUT, SHALL go to FINISH with timeout_err=1.
REQ-019 RECV SHALL shift in 47 further bits (48-bit types) or 135 (R2), MSB first, one per bit_en; bits arriving without bit_en SHALL be ignored.
REQ-020 The 48-bit frame SHALL be: transmission bit, index[5:0], arg[31:0], crc[6:0], end bit.
REQ-021 CRC7 (poly x^7+x^3+1, init 0) SHALL be computed serially over start, transmission, index and arg (40 bits) and compared with the received crc.
REQ-022 For R3, the CRC check SHALL be skipped and crc_err SHALL be 0.
REQ-023 The R2 frame SHALL be: transmission bit, 6 reserved bits, 127 payload bits, end bit. CRC7 SHALL be computed over payload bits [127:8] and compared with payload bits [7:1].
REQ-024 The transmission bit SHALL be ignored.
REQ-025 end_err SHALL be 1 when the end bit is 0.
REQ-026 FINISH SHALL last one cycle: done=1, then go to IDLE.
REQ-027 Load strobes SHALL pulse with done only when crc_err, end_err and timeout_err are all 0:
  - R1: stat_en
  - R6: rca_en; arg[31:16] is the RCA
  - R3: ocr_en
  - R2-CID: cid_en
  - R2-CSD: csd_en
  - R7: no strobe
REQ-028 index, arg and long_data SHALL hold their values until the next start.
REQ-029 start while busy SHALL be ignored.
REQ-030 Latency: done SHALL assert exactly one clk after the clk that samples the end bit.
REQ-031 A bit_en coincident with the FINISH cycle SHALL be ignored.

Reset
REQ-032 reset SHALL force IDLE, with busy, done, all error flags and all strobes at 0.
REQ-033 reset SHALL clear index, arg, long_data and all counters to 0.
REQ-034 reset mid-frame SHALL abandon the frame with no done and no strobe.

Structure
REQ-035 resp_type encodings, frame lengths (48, 136) and the CRC7 polynomial SHALL live in the shared SD package.
REQ-036 CRC7 SHALL be a sub-module sd_crc7 (serial: clear, enable, data bit, crc[6:0]), shared with the future command transmitter.

Verification
REQ-037 R7, type 7, serial 0x08_000001AA_13 (end bit included) -> done, index=8, arg=0x000001AA, no errors, no strobe.
REQ-038 Same frame with one arg bit flipped -> done with crc_err=1 and no strobe.
REQ-039 R3 with arg=0x80FF8000, CRC field 0x7F -> ocr_en pulse, crc_err=0.
REQ-040 R1 with TIMEOUT=64 and cmd_in held at 1 -> done with timeout_err=1 after the 64th bit_en.
REQ-041 R2-CID with a valid 136-bit frame -> cid_en pulse, long_data[0]=1; frame with end bit 0 -> end_err=1 and no strobe.
REQ-042 reset asserted at bit 20 of an R1 frame -> busy=0 immediately, no done; a following R1 frame is received correctly.

Source files
------------

// File: rtl/sd_resp_rx_pkg.sv
// Shared SD definitions: response-type encodings, frame lengths and the CRC7
// polynomial used by both the response receiver and the command transmitter.
package sd_resp_rx_pkg;

  localparam logic [2:0] RESP_R1     = 3'd1;
  localparam logic [2:0] RESP_R2_CID = 3'd2;
  localparam logic [2:0] RESP_R2_CSD = 3'd3;
  localparam logic [2:0] RESP_R3     = 3'd4;
  localparam logic [2:0] RESP_R6     = 3'd6;
  localparam logic [2:0] RESP_R7     = 3'd7;

  localparam int FRAME_LEN_SHORT = 48;
  localparam int FRAME_LEN_LONG  = 136;

  // x^7 + x^3 + 1 with the x^7 term implicit.
  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic is_valid_resp(input logic [2:0] rt);
    return rt inside {RESP_R1, RESP_R2_CID, RESP_R2_CSD, RESP_R3, RESP_R6, RESP_R7};
  endfunction

  function automatic logic is_long_resp(input logic [2:0] rt);
    return (rt == RESP_R2_CID) || (rt == RESP_R2_CSD);
  endfunction

endpackage

// File: rtl/sd_resp_rx_if.sv
// Handshake and result bundle between the SD host controller and the
// response receiver.
interface sd_resp_rx_if;
  logic         start;
  logic [2:0]   resp_type;
  logic         bit_en;
  logic         cmd_in;
  logic         busy;
  logic         done;
  logic         crc_err;
  logic         end_err;
  logic         timeout_err;
  logic [5:0]   index;
  logic [31:0]  arg;
  logic [127:0] long_data;
  logic         stat_en;
  logic         rca_en;
  logic         ocr_en;
  logic         cid_en;
  logic         csd_en;

  modport master (
    output start, resp_type, bit_en, cmd_in,
    input  busy, done, crc_err, end_err, timeout_err, index, arg, long_data,
           stat_en, rca_en, ocr_en, cid_en, csd_en
  );

  modport slave (
    input  start, resp_type, bit_en, cmd_in,
    output busy, done, crc_err, end_err, timeout_err, index, arg, long_data,
           stat_en, rca_en, ocr_en, cid_en, csd_en
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker, one data bit per enable, MSB first, init 0.
module sd_crc7
  import sd_resp_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data,
  output logic [6:0] crc
);

  logic feedback;
  assign feedback = crc[6] ^ data;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'd0);
    end
  end

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits for the start bit (with NCR timeout),
// shifts in a 48- or 136-bit frame, checks CRC7 and end bit, pulses load strobes.
module sd_resp_rx
  import sd_resp_rx_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         reset,
  sd_resp_rx_if.slave bus
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_RECV       = 2'd2;
  localparam logic [1:0] ST_FINISH     = 2'd3;

  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int SHIFT_W = FRAME_LEN_LONG - 2;

  // bit_cnt counts bits after the start bit; the last one is the end bit.
  localparam logic [7:0] SHORT_LAST     = 8'(FRAME_LEN_SHORT - 2);
  localparam logic [7:0] LONG_LAST      = 8'(FRAME_LEN_LONG - 2);
  localparam logic [7:0] SHORT_CRC_LAST = 8'd38;
  localparam logic [7:0] LONG_CRC_FIRST = 8'd7;
  localparam logic [7:0] LONG_CRC_LAST  = 8'd126;

  logic [1:0]         state;
  logic [2:0]         rtype;
  logic [TO_W-1:0]    to_cnt;
  logic [7:0]         bit_cnt;
  logic [SHIFT_W-1:0] sr;
  logic [6:0]         crc;

  logic         done_q, crc_err_q, end_err_q, timeout_err_q;
  logic         stat_en_q, rca_en_q, ocr_en_q, cid_en_q, csd_en_q;
  logic [5:0]   index_q;
  logic [31:0]  arg_q;
  logic [127:0] long_q;

  logic       is_long, crc_window, crc_bad, end_bad, frame_ok;
  logic       crc_clear, crc_en;
  logic [7:0] last_cnt;

  always_comb begin
    // NOTE: every variable here is assigned on every pass, so no latches.
    is_long    = is_long_resp(rtype);
    last_cnt   = is_long ? LONG_LAST : SHORT_LAST;
    crc_window = is_long ? (bit_cnt >= LONG_CRC_FIRST && bit_cnt <= LONG_CRC_LAST)
                         : (bit_cnt <= SHORT_CRC_LAST);
    // On the end-bit strobe the received CRC sits in the low 7 shift bits.
    crc_bad    = (rtype != RESP_R3) && (crc != sr[6:0]);
    end_bad    = !bus.cmd_in;
    frame_ok   = !crc_bad && !end_bad;
    crc_clear  = (state == ST_IDLE) && bus.start;
    crc_en     = bus.bit_en && (((state == ST_WAIT_START) && !bus.cmd_in) ||
                                ((state == ST_RECV) && crc_window));
  end

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (bus.cmd_in),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rtype         <= '0;
      to_cnt        <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      end_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      stat_en_q     <= 1'b0;
      rca_en_q      <= 1'b0;
      ocr_en_q      <= 1'b0;
      cid_en_q      <= 1'b0;
      csd_en_q      <= 1'b0;
      index_q       <= '0;
      arg_q         <= '0;
      long_q        <= '0;
    end else begin
      // Status and strobes are single-cycle pulses that accompany done.
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      end_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      stat_en_q     <= 1'b0;
      rca_en_q      <= 1'b0;
      ocr_en_q      <= 1'b0;
      cid_en_q      <= 1'b0;
      csd_en_q      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            rtype   <= bus.resp_type;
            to_cnt  <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            index_q <= '0;
            arg_q   <= '0;
            long_q  <= '0;
            if (is_valid_resp(bus.resp_type)) begin
              state <= ST_WAIT_START;
            end else begin
              state  <= ST_FINISH;
              done_q <= 1'b1;
            end
          end
        end

        ST_WAIT_START: begin
          if (bus.bit_en) begin
            if (!bus.cmd_in) begin
              state <= ST_RECV;
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
              state         <= ST_FINISH;
              done_q        <= 1'b1;
              timeout_err_q <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end

        ST_RECV: begin
          if (bus.bit_en) begin
            sr      <= {sr[SHIFT_W-2:0], bus.cmd_in};
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == last_cnt) begin
              state     <= ST_FINISH;
              done_q    <= 1'b1;
              crc_err_q <= crc_bad;
              end_err_q <= end_bad;
              stat_en_q <= frame_ok && (rtype == RESP_R1);
              rca_en_q  <= frame_ok && (rtype == RESP_R6);
              ocr_en_q  <= frame_ok && (rtype == RESP_R3);
              cid_en_q  <= frame_ok && (rtype == RESP_R2_CID);
              csd_en_q  <= frame_ok && (rtype == RESP_R2_CSD);
              if (is_long) begin
                long_q <= {sr[126:0], 1'b1};
              end else begin
                index_q <= sr[44:39];
                arg_q   <= sr[38:7];
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.end_err     = end_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.index       = index_q;
  assign bus.arg         = arg_q;
  assign bus.long_data   = long_q;
  assign bus.stat_en     = stat_en_q;
  assign bus.rca_en      = rca_en_q;
  assign bus.ocr_en      = ocr_en_q;
  assign bus.cid_en      = cid_en_q;
  assign bus.csd_en      = csd_en_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Bench for sd_resp_rx: directed frames plus randomized frames checked against
// a field-level model that computes CRC7 by polynomial long division.
module tb_sd_resp_rx;
  import sd_resp_rx_pkg::*;

  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_resp_rx_if bus ();

  sd_resp_rx #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic         done;
    logic         crc_err;
    logic         end_err;
    logic         timeout_err;
    logic [5:0]   index;
    logic [31:0]  arg;
    logic [127:0] long_data;
    logic [4:0]   strobes;  // stat, rca, ocr, cid, csd
  } obs_t;

  int errors = 0;
  int checks = 0;
  int stray_done = 0;
  int stray_strobe = 0;

  function automatic obs_t sample_obs();
    obs_t o;
    o.done        = bus.done;
    o.crc_err     = bus.crc_err;
    o.end_err     = bus.end_err;
    o.timeout_err = bus.timeout_err;
    o.index       = bus.index;
    o.arg         = bus.arg;
    o.long_data   = bus.long_data;
    o.strobes     = {bus.stat_en, bus.rca_en, bus.ocr_en, bus.cid_en, bus.csd_en};
    return o;
  endfunction

  // Remainder of (message * x^7) divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_div(input logic q[$], input int lo, input int hi);
    logic [7:0] rem;
    logic       b;
    rem = '0;
    for (int i = lo; i <= hi + 7; i++) begin
      b   = (i <= hi) ? q[i] : 1'b0;
      rem = {rem[6:0], b};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  function automatic obs_t model(input logic [2:0] rt, input logic q[$], input bit timed);
    obs_t       e;
    logic [6:0] rcrc;
    logic       ok;
    e      = '0;
    e.done = 1'b1;
    if (timed) begin
      e.timeout_err = 1'b1;
      return e;
    end
    if (rt == 3'd0 || rt == 3'd5) return e;
    if (rt == 3'd2 || rt == 3'd3) begin
      for (int i = 0; i < 127; i++) e.long_data[127-i] = q[8+i];
      e.long_data[0] = 1'b1;
      for (int i = 0; i < 7; i++) rcrc[6-i] = q[128+i];
      e.crc_err = (crc7_div(q, 8, 127) != rcrc);
      e.end_err = !q[135];
    end else begin
      for (int i = 0; i < 6; i++)  e.index[5-i] = q[2+i];
      for (int i = 0; i < 32; i++) e.arg[31-i]  = q[8+i];
      for (int i = 0; i < 7; i++)  rcrc[6-i]    = q[40+i];
      e.crc_err = (rt != 3'd4) && (crc7_div(q, 0, 39) != rcrc);
      e.end_err = !q[47];
    end
    ok = !e.crc_err && !e.end_err;
    e.strobes = {ok && rt == 3'd1, ok && rt == 3'd6, ok && rt == 3'd4,
                 ok && rt == 3'd2, ok && rt == 3'd3};
    return e;
  endfunction

  task automatic word_to_q(input logic [47:0] w, output logic q[$]);
    q = {};
    for (int i = 47; i >= 0; i--) q.push_back(w[i]);
  endtask

  task automatic build_short(input logic [5:0] idx, input logic [31:0] a, input logic tbit,
                             input bit bad_crc, input logic endb, output logic q[$]);
    logic [6:0] c;
    q = {};
    q.push_back(1'b0);
    q.push_back(tbit);
    for (int i = 5; i >= 0; i--)  q.push_back(idx[i]);
    for (int i = 31; i >= 0; i--) q.push_back(a[i]);
    c = crc7_div(q, 0, 39);
    if (bad_crc) c = c ^ (7'd1 << $urandom_range(0, 6));
    for (int i = 6; i >= 0; i--) q.push_back(c[i]);
    q.push_back(endb);
  endtask

  task automatic build_long(input logic [119:0] p, input bit bad_crc, input logic endb,
                            output logic q[$]);
    logic [6:0] c;
    q = {};
    q.push_back(1'b0);
    q.push_back(1'($urandom));
    repeat (6) q.push_back(1'b1);
    for (int i = 119; i >= 0; i--) q.push_back(p[i]);
    c = crc7_div(q, 8, 127);
    if (bad_crc) c = c ^ (7'd1 << $urandom_range(0, 6));
    for (int i = 6; i >= 0; i--) q.push_back(c[i]);
    q.push_back(endb);
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.done === 1'b1) stray_done++;
    if ({bus.stat_en, bus.rca_en, bus.ocr_en, bus.cid_en, bus.csd_en} !== 5'b0) stray_strobe++;
  endtask

  // Random idle cycles (with a wiggling CMD line) before each strobed bit.
  task automatic send_bit(input logic b, input bit poke);
    repeat ($urandom_range(0, 2)) begin
      bus.bit_en = 1'b0;
      bus.cmd_in = 1'($urandom);
      tick();
    end
    bus.bit_en = 1'b1;
    bus.cmd_in = b;
    if (poke) begin
      bus.start     = 1'b1;
      bus.resp_type = 3'($urandom);
    end
    tick();
    bus.bit_en = 1'b0;
    bus.start  = 1'b0;
  endtask

  task automatic transact(input logic [2:0] rt, input int pre_ones, input logic q[$],
                          input int poke_at, output obs_t got, output int pulses);
    stray_done    = 0;
    bus.start     = 1'b1;
    bus.resp_type = rt;
    bus.bit_en    = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < pre_ones; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < q.size(); i++) send_bit(q[i], i == poke_at);
    got = sample_obs();
    // A strobe during the FINISH cycle must be ignored.
    bus.bit_en = 1'b1;
    bus.cmd_in = 1'($urandom);
    tick();
    bus.bit_en = 1'b0;
    repeat (2) tick();
    pulses = stray_done;
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = sample_obs();
    checks++;
    if (got !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_r7_vector();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    word_to_q(48'h08_000001AA_13, q);
    transact(RESP_R7, 3, q, -1, got, pulses);
    exp       = '0;
    exp.done  = 1'b1;
    exp.index = 6'd8;
    exp.arg   = 32'h000001AA;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL r7_vector got=%h exp=%h", got, exp);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL r7_done_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_crc_flip();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    word_to_q(48'h08_000001AB_13, q);
    transact(RESP_R7, 0, q, -1, got, pulses);
    exp         = '0;
    exp.done    = 1'b1;
    exp.crc_err = 1'b1;
    exp.index   = 6'd8;
    exp.arg     = 32'h000001AB;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL r7_crc_flip got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_r3();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    word_to_q({2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}, q);
    transact(RESP_R3, 1, q, -1, got, pulses);
    exp         = '0;
    exp.done    = 1'b1;
    exp.index   = 6'h3F;
    exp.arg     = 32'h80FF8000;
    exp.strobes = 5'b00100;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL r3_ocr got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_timeout();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    q = {};
    transact(RESP_R1, TIMEOUT, q, -1, got, pulses);
    exp             = '0;
    exp.done        = 1'b1;
    exp.timeout_err = 1'b1;
    checks++;
    if (got !== exp || pulses != 1) begin
      errors++;
      $display("FAIL timeout_64 got=%h pulses=%0d exp=%h pulses=1", got, pulses, exp);
    end
    // One strobe short of the limit, the start bit still wins.
    build_short(6'($urandom), $urandom, 1'b0, 1'b0, 1'b1, q);
    transact(RESP_R1, TIMEOUT - 1, q, -1, got, pulses);
    exp = model(RESP_R1, q, 1'b0);
    checks++;
    if (got !== exp || pulses != 1) begin
      errors++;
      $display("FAIL timeout_63_ok got=%h pulses=%0d exp=%h pulses=1", got, pulses, exp);
    end
  endtask

  task automatic test_r2();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    build_long(120'({$urandom, $urandom, $urandom, $urandom}), 1'b0, 1'b1, q);
    transact(RESP_R2_CID, 2, q, -1, got, pulses);
    exp = model(RESP_R2_CID, q, 1'b0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL r2_cid_frame got=%h exp=%h", got, exp);
    end
    checks++;
    if (got.strobes !== 5'b00010 || got.long_data[0] !== 1'b1) begin
      errors++;
      $display("FAIL r2_cid_strobe got=%b/%b exp=00010/1", got.strobes, got.long_data[0]);
    end
    q[135] = 1'b0;
    transact(RESP_R2_CID, 0, q, -1, got, pulses);
    checks++;
    if (got.end_err !== 1'b1 || got.crc_err !== 1'b0 || got.strobes !== 5'b0) begin
      errors++;
      $display("FAIL r2_end_err got=%b%b/%b exp=10/00000", got.end_err, got.crc_err, got.strobes);
    end
  endtask

  task automatic test_no_resp();
    logic q[$];
    obs_t got;
    int   pulses;
    q = {};
    for (int k = 0; k < 2; k++) begin
      transact((k == 0) ? 3'd0 : 3'd5, 0, q, -1, got, pulses);
      checks++;
      if (got !== model(3'd0, q, 1'b0) || pulses != 1) begin
        errors++;
        $display("FAIL no_resp_%0d got=%h pulses=%0d exp_done_only", k, got, pulses);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    for (int k = 0; k < 2; k++) begin
      build_short(6'($urandom), $urandom, 1'($urandom), 1'b0, 1'b1, q);
      transact(RESP_R6, 1, q, (k == 0) ? 0 : 10, got, pulses);
      exp = model(RESP_R6, q, 1'b0);
      checks++;
      if (got !== exp || pulses != 1) begin
        errors++;
        $display("FAIL start_ignored_%0d got=%h pulses=%0d exp=%h pulses=1", k, got, pulses, exp);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic q[$];
    obs_t got, exp;
    int   pulses;
    build_short(6'($urandom), $urandom, 1'b0, 1'b0, 1'b1, q);
    bus.start     = 1'b1;
    bus.resp_type = RESP_R1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(q[i], 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy got=%b exp=1", bus.busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_now got=%b%b exp=00", bus.busy, bus.done);
    end
    @(negedge clk);
    reset        = 1'b0;
    stray_done   = 0;
    stray_strobe = 0;
    for (int i = 20; i < 48; i++) send_bit(q[i], 1'b0);
    repeat (3) tick();
    checks++;
    if (stray_done != 0 || stray_strobe != 0) begin
      errors++;
      $display("FAIL abandoned_frame got=%0d/%0d exp=0/0", stray_done, stray_strobe);
    end
    build_short(6'($urandom), $urandom, 1'b1, 1'b0, 1'b1, q);
    transact(RESP_R1, 0, q, -1, got, pulses);
    exp = model(RESP_R1, q, 1'b0);
    checks++;
    if (got !== exp || pulses != 1) begin
      errors++;
      $display("FAIL after_reset_r1 got=%h pulses=%0d exp=%h pulses=1", got, pulses, exp);
    end
  endtask

  task automatic test_random();
    logic [2:0] rt;
    logic       q[$];
    obs_t       got, exp;
    int         pulses, mode, pre, poke;
    bit         valid, timed;
    for (int n = 0; n < 24; n++) begin
      rt    = 3'($urandom_range(0, 7));
      mode  = $urandom_range(0, 9);
      valid = !(rt == 3'd0 || rt == 3'd5);
      timed = valid && (mode == 0);
      pre   = timed ? TIMEOUT : $urandom_range(0, 6);
      q     = {};
      if (!valid) pre = 0;
      else if (!timed) begin
        if (rt == 3'd2 || rt == 3'd3)
          build_long(120'({$urandom, $urandom, $urandom, $urandom}), mode inside {1, 2},
                     (mode == 3) ? 1'b0 : 1'b1, q);
        else
          build_short(6'($urandom), $urandom, 1'($urandom), mode inside {1, 2},
                      (mode == 3) ? 1'b0 : 1'b1, q);
      end
      poke = ($urandom_range(0, 1) == 1 && q.size() > 0) ? $urandom_range(0, q.size() - 1) : -1;
      transact(rt, pre, q, poke, got, pulses);
      exp = model(rt, q, timed);
      checks++;
      if (got !== exp || pulses != 1) begin
        errors++;
        $display("FAIL random_%0d rt=%0d got=%h pulses=%0d exp=%h pulses=1",
                 n, rt, got, pulses, exp);
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.resp_type = 3'd0;
    bus.bit_en    = 1'b0;
    bus.cmd_in    = 1'b1;
    reset         = 1'b1;
    test_reset();
    test_r7_vector();
    test_crc_flip();
    test_r3();
    test_timeout();
    test_r2();
    test_no_resp();
    test_start_ignored();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout exp=finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
